load_store_unit: RTL and testbench

Data-side stage downstream of the single-cycle core's ALU. It takes the ALU-computed effective address, rs2 value and funct3 for RV32I loads/stores and runs a valid/ready transaction on a word-wide data memory bus. It stalls the core (holds the PC) until the access completes, then returns the aligned, extended load value for the rd write-back mux. It also performs byte-lane steering, write strobes and alignment checking.

---
 rtl/lsu_pkg.sv | 60 ++++++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

   localparam int XLEN      = 32;
   localparam int BYTE_W    = 8;
   localparam int HALF_W    = 16;
   localparam int NUM_LANES = XLEN / BYTE_W;

   // RV32I funct3 width/sign codes (loads and stores share encodings)
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Everything the bus side needs, held stable for the whole BUSY phase
   typedef struct packed {
      logic                 we;
      logic [XLEN-1:0]      addr;
      logic [NUM_LANES-1:0] wstrb;
      logic [XLEN-1:0]      wdata;
   } mem_req_t;

   // Unsupported width codes are folded into the misaligned path so the
   // core only has one reject signal to handle.
   function automatic logic is_illegal(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (write) begin
         case (f3)
            SB:      bad = 1'b0;
            SH:      bad = off[0];
            SW:      bad = |off;
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            LB, LBU: bad = 1'b0;
            LH, LHU: bad = off[0];
            LW:      bad = |off;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and sign/zero-extends the addressed byte/half/word of a read word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [2:0]      funct3,
   input  logic [1:0]      byte_off,
   output logic [XLEN-1:0] load_value
);

   logic [BYTE_W-1:0] sel_byte;
   logic [HALF_W-1:0] sel_half;

   // Pick the lane, then extend according to the width/sign code
   always_comb begin
      sel_byte   = '0;
      sel_half   = '0;
      load_value = '0;
      case (byte_off)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      sel_half = byte_off[1] ? word[31:16] : word[15:0];
      case (funct3)
         LB:      load_value = {{(XLEN-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
         LBU:     load_value = {{(XLEN-BYTE_W){1'b0}}, sel_byte};
         LH:      load_value = {{(XLEN-HALF_W){sel_half[HALF_W-1]}}, sel_half};
         LHU:     load_value = {{(XLEN-HALF_W){1'b0}}, sel_half};
         LW:      load_value = word;
         default: load_value = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane steering, alignment check, valid/ready data bus access; LSU_TIMEOUT_EN adds a bus timeout.
// Latency: 3 cycles minimum (IDLE -> BUSY -> DONE), +1 per mem_ready wait state.
// Backpressure: holds stall high and bus request stable until mem_ready (or timeout abort).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_write,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      addr,
   input  logic [XLEN-1:0]      wdata,
   output logic                 stall,
   output logic [XLEN-1:0]      load_value,
   output logic                 done,
   output logic                 misaligned,
   output logic                 bus_error,
   output logic                 mem_valid,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_addr,
   output logic [NUM_LANES-1:0] mem_wstrb,
   output logic [XLEN-1:0]      mem_wdata,
   input  logic                 mem_ready,
   input  logic [XLEN-1:0]      mem_rdata
);

   lsu_state_t      state, state_nxt;
   mem_req_t        req_q, req_steer;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] aligned;
   logic            err_q;
   logic            illegal;
   logic            accept;
   logic            timeout;

   assign illegal = is_illegal(req_write, funct3, addr[1:0]);
   assign accept  = (state == IDLE) && req_valid && !illegal;

   // Build the word-aligned bus request with store data replicated onto every lane
   always_comb begin
      req_steer       = '0;
      req_steer.we    = req_write;
      req_steer.addr  = {addr[XLEN-1:2], 2'b00};
      if (req_write) begin
         case (funct3)
            SB: begin
               req_steer.wstrb = 4'b0001 << addr[1:0];
               req_steer.wdata = {NUM_LANES{wdata[BYTE_W-1:0]}};
            end
            SH: begin
               req_steer.wstrb = 4'b0011 << addr[1:0];
               req_steer.wdata = {2{wdata[HALF_W-1:0]}};
            end
            default: begin
               req_steer.wstrb = 4'b1111;
               req_steer.wdata = wdata;
            end
         endcase
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] busy_cnt;

   // Count BUSY cycles that went by without mem_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt <= '0;
      end else if (accept) begin
         busy_cnt <= '0;
      end else if (state == BUSY && !mem_ready) begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end

   // Abort on the last allowed wait cycle; a same-cycle mem_ready completes normally
   assign timeout   = (state == BUSY) && !mem_ready &&
                      (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus_error = (state == DONE) && err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout            = 1'b0;
   assign bus_error          = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      done       = 1'b0;
      mem_valid  = 1'b0;
      misaligned = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (illegal) begin
                  misaligned = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            mem_valid = 1'b1;
            stall     = 1'b1;
            if (mem_ready || timeout) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Instruction retires here; req_valid is still the same instruction
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            req_q <= req_steer;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            err_q <= 1'b0;
         end
         if (state == BUSY && mem_ready) begin
            rdata_q <= mem_rdata;
         end
         if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_wstrb = req_q.wstrb;
   assign mem_wdata = req_q.wdata;

   lsu_load_align u_align (
      .word       (rdata_q),
      .funct3     (f3_q),
      .byte_off   (off_q),
      .load_value (aligned)
   );

   assign load_value = (state == DONE && !req_q.we && !err_q) ? aligned : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Latency: n/a.
// Backpressure: mem_ready driven directly by the bench.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_value;
   logic        done;
   logic        misaligned;
   logic        bus_error;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .load_value (load_value),
      .done       (done),
      .misaligned (misaligned),
      .bus_error  (bus_error),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, checks 1 unit later
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_load);
      nxt();
      req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
      mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;  // ready outside BUSY is ignored
      #1;
      chk({tag, ".idle_stall"}, stall, 1);
      chk({tag, ".idle_mem_valid"}, mem_valid, 0);
      chk({tag, ".idle_misaligned"}, misaligned, 0);
      for (int i = 0; i <= waits; i++) begin
         nxt();
         mem_ready = (i == waits);
         mem_rdata = rd;
         #1;
         chk({tag, ".busy_mem_valid"}, mem_valid, 1);
         chk({tag, ".busy_stall"}, stall, 1);
         chk({tag, ".busy_done"}, done, 0);
         chk({tag, ".mem_addr"}, mem_addr, exp_addr);
         chk({tag, ".mem_we"}, mem_we, w);
         chk({tag, ".mem_wstrb"}, mem_wstrb, exp_strb);
         if (w) chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
      end
      nxt();
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #1;
      chk({tag, ".done"}, done, 1);
      chk({tag, ".done_stall"}, stall, 0);
      chk({tag, ".done_mem_valid"}, mem_valid, 0);
      chk({tag, ".load_value"}, load_value, exp_load);
      chk({tag, ".bus_error"}, bus_error, 0);
      nxt();
      req_valid = 1'b0;
      #1;
      chk({tag, ".after_mem_valid"}, mem_valid, 0);
      chk({tag, ".after_done"}, done, 0);
      chk({tag, ".after_stall"}, stall, 0);
   endtask

   task automatic misal(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a);
      nxt();
      req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
      mem_ready = 1'b0;
      #1;
      chk({tag, ".misaligned"}, misaligned, 1);
      chk({tag, ".stall"}, stall, 0);
      chk({tag, ".load_value"}, load_value, 0);
      for (int i = 0; i < 2; i++) begin
         nxt();
         #1;
         chk({tag, ".mem_valid"}, mem_valid, 0);
         chk({tag, ".done"}, done, 0);
         chk({tag, ".stall_held"}, stall, 0);
      end
      nxt();
      req_valid = 1'b0;
      #1;
      chk({tag, ".cleared"}, misaligned, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
      nxt();
      nxt();
      #1;
      chk("rst.stall", stall, 0);
      chk("rst.done", done, 0);
      chk("rst.mem_valid", mem_valid, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wstrb", mem_wstrb, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.load_value", load_value, 0);
      chk("rst.bus_error", bus_error, 0);
      chk("rst.misaligned", misaligned, 0);
      rst = 1'b0;

      // Stores: address, strobe and lane steering
      access("sw",  1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0,
             32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      access("sb",  1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0,
             32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
      access("sh",  1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 2,
             32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0);

      // Loads: extraction and extension
      access("lb",  1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F0_3456, 1,
             32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FFF0);
      access("lbu", 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0,
             32'h0000_0100, 4'b0000, 32'h0, 32'h0000_00F0);
      access("lhu", 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0,
             32'h0000_0100, 4'b0000, 32'h0, 32'h0000_12F0);
      access("lb1", 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h12F0_3456, 0,
             32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0034);
      access("lh",  1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h0000_8001, 0,
             32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_8001);
      access("lw5", 1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'hCAFE_F00D, 5,
             32'h0000_0108, 4'b0000, 32'h0, 32'hCAFE_F00D);

      // Alignment and illegal width rejection
      misal("lw_mis", 1'b0, 3'b010, 32'h0000_0106);
      misal("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
      misal("sw_mis", 1'b1, 3'b010, 32'h0000_0102);
      misal("ld_011", 1'b0, 3'b011, 32'h0000_0100);
      misal("st_100", 1'b1, 3'b100, 32'h0000_0100);

      // Reset while BUSY, with a same-cycle mem_ready that must be discarded
      nxt();
      req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_010C;
      mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
      #1;
      chk("rstbusy.idle_stall", stall, 1);
      nxt();
      #1;
      chk("rstbusy.busy_mem_valid", mem_valid, 1);
      rst = 1'b1; mem_ready = 1'b1;
      nxt();
      rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
      #1;
      chk("rstbusy.mem_valid", mem_valid, 0);
      chk("rstbusy.done", done, 0);
      chk("rstbusy.stall", stall, 0);
      chk("rstbusy.mem_addr", mem_addr, 0);
      nxt();
      #1;
      chk("rstbusy.no_done", done, 0);
      chk("rstbusy.still_idle", mem_valid, 0);

`ifdef LSU_TIMEOUT_EN
      // Timeout after 4 BUSY cycles with no mem_ready
      nxt();
      req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0110;
      mem_ready = 1'b0; mem_rdata = 32'h7777_7777;
      #1;
      chk("to.idle_stall", stall, 1);
      for (int i = 0; i < 4; i++) begin
         nxt();
         #1;
         chk("to.busy_mem_valid", mem_valid, 1);
         chk("to.busy_bus_error", bus_error, 0);
         chk("to.busy_done", done, 0);
      end
      nxt();
      #1;
      chk("to.done", done, 1);
      chk("to.bus_error", bus_error, 1);
      chk("to.load_value", load_value, 0);
      chk("to.mem_valid", mem_valid, 0);
      nxt();
      req_valid = 1'b0;
      #1;
      chk("to.after_bus_error", bus_error, 0);
      chk("to.after_done", done, 0);
      chk("to.after_mem_valid", mem_valid, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
